// File: rtl/shift_add_explog_pkg.sv
// rtl/shift_add_explog_pkg.sv - shared types, constants and helpers for the shift-add exp/log unit
// Contents: FSM state enum, mode encodings, fixed-point ONE helper and the
// per-stage shift amount used by the integer range-reduction stages.
package shift_add_explog_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FRAC,
        S_DONE
    } state_e;

    localparam logic MODE_EXP = 1'b0;
    localparam logic MODE_LOG = 1'b1;

    // Shift amounts are carried at this width so they cover both the
    // power-of-two range stages and the fractional step index k.
    localparam int unsigned SH_W = 32;

    // 1.0 in a Q?.frac fixed-point format; callers truncate to their width.
    function automatic logic [127:0] one_of(input int unsigned frac);
        return 128'(1) << frac;
    endfunction

    // Range-reduction stage i divides by 2^(2^(int_bits-1-i)).
    function automatic logic [SH_W-1:0] stage_shift(input int unsigned int_bits,
                                                    input int unsigned i);
        return SH_W'(1) << (int_bits - 1 - i);
    endfunction

endpackage

// File: rtl/shift_add_explog_step.sv
// rtl/shift_add_explog_step.sv - one combinational shift-add iteration
// Ports:
//   int_stage      1: range stage (acc >> sh) instead of fractional step (acc - acc>>sh)
//   sh             shift amount (s_i for range stages, k for fractional steps)
//   t              table constant for this iteration
//   a / a_n        EXP: remaining argument r; LOG: operand x (passed through)
//   acc / acc_n    product accumulator
//   is_log, z/z_n  LOG mode select and log accumulator (SHIFT_ADD_LOG_EN only)
// Macro: SHIFT_ADD_LOG_EN adds the LOG datapath.
module shift_add_explog_step
    import shift_add_explog_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             int_stage,
    input  logic [SH_W-1:0]  sh,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] acc,
`ifdef SHIFT_ADD_LOG_EN
    input  logic             is_log,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_n,
`endif
    output logic [WIDTH-1:0] a_n,
    output logic [WIDTH-1:0] acc_n
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] cand;
    logic             take;

    always_comb begin
        shifted = acc >> sh;
        cand    = int_stage ? shifted : (acc - shifted);
        // EXP consumes table weight from r; LOG accepts the step while the
        // candidate product stays at or above the operand.
        take    = (a >= t);
`ifdef SHIFT_ADD_LOG_EN
        if (is_log) begin
            take = (cand >= a);
        end
`endif
        acc_n = take ? cand : acc;
        a_n   = a;
`ifdef SHIFT_ADD_LOG_EN
        z_n = z;
        if (is_log) begin
            if (take) begin
                z_n = z + t;
            end
        end else if (take) begin
            a_n = a - t;
        end
`else
        if (take) begin
            a_n = a - t;
        end
`endif
    end

endmodule

// File: rtl/shift_add_explog.sv
// rtl/shift_add_explog.sv - iterative shift-add exp(-x) / -ln(x) unit with valid/ready handshakes
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake (in_ready only while idle)
//   mode, x                0=EXP, 1=LOG; operand, both latched on accept
//   lut                    constant table, entry i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready    result handshake; y/err held until accepted
//   y, err                 result and saturation flag
// Macro: SHIFT_ADD_LOG_EN enables LOG mode; otherwise mode is ignored and err=0.
module shift_add_explog
    import shift_add_explog_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int FRAC     = 32,
    parameter int INT_BITS = 5,
    parameter int ITERS    = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            mode,
    input  logic [WIDTH-1:0]                x,
    input  logic [(INT_BITS+ITERS)*WIDTH-1:0] lut,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                y,
    output logic                            err
);

    localparam int NT      = INT_BITS + ITERS;
    localparam int CNT_MAX = (ITERS > INT_BITS) ? ITERS : INT_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NT);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(one_of(FRAC));

    logic [WIDTH-1:0] tbl [NT];
    for (genvar g = 0; g < NT; g++) begin : g_tbl
        assign tbl[g] = lut[g*WIDTH +: WIDTH];
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] a_n, acc_n;
    logic [IDX_W-1:0] tbl_idx;
    logic [SH_W-1:0]  sh;
    logic             int_stage;
`ifdef SHIFT_ADD_LOG_EN
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] z_q, z_d, z_n;
    logic             err_q, err_d;
`else
    logic             unused_mode;
    assign unused_mode = mode;
`endif

    assign int_stage = (state_q == S_SHIFT);
    assign tbl_idx   = int_stage ? IDX_W'(cnt_q) : (IDX_W'(INT_BITS) + IDX_W'(cnt_q));
    assign sh        = int_stage ? stage_shift(INT_BITS, 32'(cnt_q))
                                 : (SH_W'(cnt_q) + SH_W'(1));

    shift_add_explog_step #(.WIDTH(WIDTH)) u_step (
        .int_stage (int_stage),
        .sh        (sh),
        .t         (tbl[tbl_idx]),
        .a         (a_q),
        .acc       (acc_q),
`ifdef SHIFT_ADD_LOG_EN
        .is_log    (mode_q == MODE_LOG),
        .z         (z_q),
        .z_n       (z_n),
`endif
        .a_n       (a_n),
        .acc_n     (acc_n)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        acc_d     = acc_q;
        y_d       = y_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef SHIFT_ADD_LOG_EN
        mode_d    = mode_q;
        z_d       = z_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = x;
                    acc_d   = ONE;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
`ifdef SHIFT_ADD_LOG_EN
                    mode_d  = mode;
                    z_d     = '0;
`endif
                end
            end
            S_SHIFT: begin
                a_d   = a_n;
                acc_d = acc_n;
`ifdef SHIFT_ADD_LOG_EN
                z_d   = z_n;
`endif
                if (cnt_q == CNT_W'(INT_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FRAC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FRAC: begin
                a_d   = a_n;
                acc_d = acc_n;
`ifdef SHIFT_ADD_LOG_EN
                z_d   = z_n;
`endif
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    // Result is taken from the final step's outputs so it is
                    // ready the same edge the FSM enters DONE.
`ifdef SHIFT_ADD_LOG_EN
                    if (mode_q == MODE_LOG) begin
                        if (a_q == '0) begin
                            y_d   = '1;
                            err_d = 1'b1;
                        end else if (a_q > ONE) begin
                            y_d   = '0;
                            err_d = 1'b1;
                        end else begin
                            y_d   = z_n;
                            err_d = 1'b0;
                        end
                    end else begin
                        y_d   = acc_n;
                        err_d = 1'b0;
                    end
`else
                    y_d = acc_n;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
`ifdef SHIFT_ADD_LOG_EN
            mode_q  <= MODE_EXP;
            z_q     <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
`ifdef SHIFT_ADD_LOG_EN
            mode_q  <= mode_d;
            z_q     <= z_d;
            err_q   <= err_d;
`endif
        end
    end

    assign y = y_q;
`ifdef SHIFT_ADD_LOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_add_explog.sv
// tb/tb_shift_add_explog.sv - self-checking bench for shift_add_explog
module tb_shift_add_explog;

    localparam int WIDTH    = 64;
    localparam int FRAC     = 32;
    localparam int INT_BITS = 5;
    localparam int ITERS    = 32;
    localparam int NT       = INT_BITS + ITERS;
    localparam int LAT      = INT_BITS + ITERS + 1;
    localparam logic [63:0] ONE = 64'h1_0000_0000;
`ifdef SHIFT_ADD_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  mode = 1'b0;
    logic [WIDTH-1:0]      x = '0;
    logic [NT*WIDTH-1:0]   lut = '0;
    logic                  out_ready = 1'b1;
    logic                  in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      y;
    logic                  err;

    shift_add_explog #(.WIDTH(WIDTH), .FRAC(FRAC), .INT_BITS(INT_BITS), .ITERS(ITERS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x         (x),
        .lut       (lut),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] y;
        logic        err;
        int          due;
    } exp_t;
    exp_t        sb[$];
    int          ov_cyc[$];
    bit          cmp_first = 1'b1;
    logic [63:0] tbl [NT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_near(input string name, input logic [63:0] act,
                              input logic [63:0] req, input logic [63:0] tol);
        logic [63:0] d;
        d = (act > req) ? act - req : req - act;
        n_cmp++;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h +/- %0d", name, act, req, tol);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [63:0] q32(input real v);
        longint r;
        r = longint'(v * 4294967296.0);
        return 64'(r);
    endfunction

    // Reference: the exp/log recurrences applied directly as whole-number
    // arithmetic over the table, with the boundary rules folded in at the end.
    function automatic logic [64:0] model(input logic m, input logic [63:0] xv);
        logic [63:0] r, acc, z, c;
        int unsigned s;
        logic lg;
        lg  = m & LOG_EN;
        r   = xv;
        acc = ONE;
        z   = '0;
        for (int i = 0; i < NT; i++) begin
            s = (i < INT_BITS) ? (32'd1 << (INT_BITS - 1 - i)) : 32'(i - INT_BITS + 1);
            c = (i < INT_BITS) ? (acc >> s) : (acc - (acc >> s));
            if (lg) begin
                if (c >= xv) begin
                    acc = c;
                    z   = z + tbl[i];
                end
            end else if (r >= tbl[i]) begin
                r   = r - tbl[i];
                acc = c;
            end
        end
        if (!lg) return {1'b0, acc};
        if (xv == 0) return {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        if (xv > ONE) return {1'b1, 64'h0};
        return {1'b0, z};
    endfunction

    // Compare process: handshake/timing/result checks every meaningful cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", {63'b0, in_ready}, {63'b0, sb.size() == 0});
            if (out_valid) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    if (cmp_first) begin
                        check("latency", 64'(cyc), 64'(sb[0].due));
                        ov_cyc.push_back(cyc);
                        cmp_first = 1'b0;
                    end
                    check("y_model", y, sb[0].y);
                    check("err_model", {63'b0, err}, {63'b0, sb[0].err});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        cmp_first = 1'b1;
                    end
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                fail_now("result_late");
                void'(sb.pop_front());
                cmp_first = 1'b1;
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
    task automatic send(input logic m, input logic [63:0] xv);
        int n;
        logic [64:0] e;
        exp_t it;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            fail_now("send_wait");
            return;
        end
        in_valid = 1'b1;
        mode     = m;
        x        = xv;
        e        = model(m, xv);
        it.y     = e[63:0];
        it.err   = e[64];
        it.due   = cyc + LAT;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(it);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (sb.size() != 0 && n < max_cyc);
        if (sb.size() != 0) fail_now("drain");
    endtask

    task automatic run1(input string name, input logic m, input logic [63:0] xv,
                        input logic [63:0] ylit, input logic [63:0] tol, input logic elit);
        int n;
        send(m, xv);
        for (n = 0; n < LAT + 10; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) begin
            fail_now(name);
        end else begin
            check_near(name, y, ylit, tol);
            check({name, "_err"}, {63'b0, err}, {63'b0, elit});
        end
        drain(100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [63:0] vec [6];

    initial begin
        for (int i = 0; i < INT_BITS; i++)
            tbl[i] = q32((2.0 ** (INT_BITS - 1 - i)) * $ln(2.0));
        for (int k = 1; k <= ITERS; k++)
            tbl[INT_BITS + k - 1] = q32(-$ln(1.0 - 1.0 / (2.0 ** k)));
        for (int i = 0; i < NT; i++) lut[i*WIDTH +: WIDTH] = tbl[i];

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_y", y, 64'd0);
        check("rst_err", {63'b0, err}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Literal anchors
        run1("exp_x0", 1'b0, 64'h0, ONE, 64'd0, 1'b0);
        run1("exp_ln2", 1'b0, 64'hB172_17F8, 64'h8000_0000, 64'd64, 1'b0);
        run1("exp_one", 1'b0, ONE, 64'h5E2D_58D9, 64'd64, 1'b0);
        run1("exp_big", 1'b0, 64'h40_0000_0000, 64'h0, 64'd64, 1'b0);
        run1("exp_max", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'd64, 1'b0);
`ifdef SHIFT_ADD_LOG_EN
        run1("log_half", 1'b1, 64'h8000_0000, 64'hB172_17F8, 64'd64, 1'b0);
        run1("log_quarter", 1'b1, 64'h4000_0000, 64'h1_62E4_2FF0, 64'd64, 1'b0);
        run1("log_zero", 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        run1("log_two", 1'b1, 64'h2_0000_0000, 64'h0, 64'd0, 1'b1);
        run1("log_one", 1'b1, ONE, 64'h0, 64'd0, 1'b0);
`else
        run1("mode_ignored", 1'b1, 64'h0, ONE, 64'd0, 1'b0);
        run1("mode_ignored_ln2", 1'b1, 64'hB172_17F8, 64'h8000_0000, 64'd64, 1'b0);
`endif

        // Backpressure: result held, busy, extra operand ignored
        out_ready = 1'b0;
        send(1'b0, ONE);
        for (int n = 0; n < LAT + 10 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        if (!out_valid) fail_now("bp_wait");
        in_valid = 1'b1;
        mode     = 1'b0;
        x        = 64'h0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_out_valid", {63'b0, out_valid}, 64'd1);
        check("bp_in_ready", {63'b0, in_ready}, 64'd0);
        check_near("bp_y", y, 64'h5E2D_58D9, 64'd64);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ov", {63'b0, out_valid}, 64'd0);
        check("bp_release_ir", {63'b0, in_ready}, 64'd1);
        drain(100);

        // Reset during FRAC aborts the operation
        send(1'b0, ONE);
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {63'b0, out_valid}, 64'd0);
        check("abort_in_ready", {63'b0, in_ready}, 64'd1);
        check("abort_y", y, 64'd0);
        sb.delete();
        cmp_first = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
        end
        check("abort_no_stale", {63'b0, out_valid}, 64'd0);
        run1("after_abort", 1'b0, ONE, 64'h5E2D_58D9, 64'd64, 1'b0);

        // Back-to-back throughput
        ov_cyc.delete();
        send(1'b0, 64'h3000_0000);
        send(1'b0, 64'h2_8000_0000);
        send(1'b0, 64'hB172_17F8);
        drain(200);
        if (ov_cyc.size() < 3) begin
            fail_now("b2b_results");
        end else begin
            check("b2b_gap1", 64'(ov_cyc[1] - ov_cyc[0]), 64'd39);
            check("b2b_gap2", 64'(ov_cyc[2] - ov_cyc[1]), 64'd39);
        end

        // Model-checked sweep, both modes
        vec[0] = 64'h0000_0001;
        vec[1] = 64'h3000_0000;
        vec[2] = 64'hC000_0000;
        vec[3] = 64'hFFFF_FFFF;
        vec[4] = 64'h2_8000_0000;
        vec[5] = 64'h1234_5678_9ABC;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, vec[i]);
            send(1'b1, vec[i]);
        end
        drain(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
